// File: rtl/leb128_pkg.sv
// Shared LEB128 constants and sizing helpers for the stream decoder and the
// combinational window unpackers.
package leb128_pkg;

  localparam int GLUE_BIT = 7;
  localparam int SIGN_BIT = 6;

  function automatic int leb128_max_bytes(input int width);
    return (width + 6) / 7;
  endfunction

  function automatic int leb128_len_width(input int width);
    return $clog2(leb128_max_bytes(width) + 1);
  endfunction

endpackage

// File: rtl/leb128_finalise.sv
// Merges the terminating byte into the accumulator, applies sign/zero fill and
// flags malformed final bytes. Purely combinational.
module leb128_finalise
  import leb128_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIGNED = 1,
  localparam int MAX_BYTES = leb128_max_bytes(WIDTH),
  localparam int LW = leb128_len_width(WIDTH)
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [7:0]       term_byte,
  input  logic [LW-1:0]    cnt,
  output logic [WIDTH-1:0] value,
  output logic             err
);

  localparam int FULL = 7 * MAX_BYTES;

  logic [FULL-1:0] wide;

  always_comb begin
    int top;
    wide  = FULL'(acc) | (FULL'(term_byte[6:0]) << (7 * int'(cnt)));
    top   = 7 * (int'(cnt) + 1);
    value = wide[WIDTH-1:0];
    for (int i = 0; i < WIDTH; i++)
      if (SIGNED != 0 && i >= top) value[i] = term_byte[SIGN_BIT];
    err = 1'b0;
    // Only the last permitted byte can carry bits beyond WIDTH.
    if (int'(cnt) == MAX_BYTES - 1) begin
      err = term_byte[GLUE_BIT];
      for (int i = WIDTH; i < FULL; i++)
        if (wide[i] != ((SIGNED != 0) ? value[WIDTH-1] : 1'b0)) err = 1'b1;
    end
  end

endmodule

// File: rtl/leb128_stream_decoder.sv
// Byte-serial LEB128 decoder: accumulates one byte per cycle and presents the
// decoded value on a registered valid/ready output.
module leb128_stream_decoder
  import leb128_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIGNED = 1,
  localparam int MAX_BYTES = leb128_max_bytes(WIDTH),
  localparam int LW = leb128_len_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LW-1:0]    out_len,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int FULL = 7 * MAX_BYTES;

  logic [WIDTH-1:0] acc;
  logic [LW-1:0]    cnt;
  logic [WIDTH-1:0] fin_value;
  logic             fin_err;
  logic             accept;
  logic             last;
  logic [FULL-1:0]  shifted;

  // A stalled output blocks input so no partial value can advance past it.
  assign in_ready = !(out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = !in_data[GLUE_BIT] || (cnt == LW'(MAX_BYTES - 1));
  assign shifted  = FULL'(in_data[6:0]) << (7 * int'(cnt));

  leb128_finalise #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_finalise (
    .acc       (acc),
    .term_byte (in_data),
    .cnt       (cnt),
    .value     (fin_value),
    .err       (fin_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_len   <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept) begin
        if (last) begin
          acc       <= '0;
          cnt       <= '0;
          out_data  <= fin_value;
          out_len   <= cnt + LW'(1);
          out_err   <= fin_err;
          out_valid <= 1'b1;
        end else begin
          acc <= acc | shifted[WIDTH-1:0];
          cnt <= cnt + LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_leb128_stream_decoder.sv
// Bench for leb128_stream_decoder: unsigned 32, signed 32 and signed 64 instances,
// directed vectors, stall/reset sequences and randomized streams vs a model.
module tb_leb128_stream_decoder;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [2:0][7:0] in_data;
  logic [2:0]     in_valid;
  logic [2:0]     out_ready;
  wire  [2:0]     in_ready;
  wire  [2:0]     out_valid;
  wire  [2:0]     out_err;
  logic [31:0]    od0, od1;
  logic [63:0]    od2;
  logic [2:0]     ol0, ol1;
  logic [3:0]     ol2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  leb128_stream_decoder #(.WIDTH(32), .SIGNED(0)) u_u32 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(od0), .out_len(ol0), .out_err(out_err[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]));

  leb128_stream_decoder #(.WIDTH(32), .SIGNED(1)) u_s32 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(od1), .out_len(ol1), .out_err(out_err[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]));

  leb128_stream_decoder #(.WIDTH(64), .SIGNED(1)) u_s64 (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .out_data(od2), .out_len(ol2), .out_err(out_err[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]));

  function automatic int wid(input int k);
    return (k == 2) ? 64 : 32;
  endfunction

  function automatic bit sgn(input int k);
    return k != 0;
  endfunction

  function automatic int mb(input int k);
    return (wid(k) + 6) / 7;
  endfunction

  function automatic logic [63:0] get_data(input int k);
    case (k)
      0:       return {32'b0, od0};
      1:       return {32'b0, od1};
      default: return od2;
    endcase
  endfunction

  function automatic int get_len(input int k);
    case (k)
      0:       return int'(ol0);
      1:       return int'(ol1);
      default: return int'(ol2);
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: value of the byte sequence as a wide integer, then range check.
  function automatic void model(input int k, input logic [79:0] b, input int n,
                                output logic [63:0] val, output logic err);
    logic [127:0] v, ext, lo_mask;
    int w;
    w = wid(k);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (128'(b[8*i +: 7]) << (7 * i));
    if (sgn(k) && b[8*(n-1)+6]) v = v | ~((128'd1 << (7 * n)) - 128'd1);
    lo_mask = (128'd1 << w) - 128'd1;
    if (sgn(k) && v[w-1]) ext = (v & lo_mask) | ~lo_mask;
    else ext = v & lo_mask;
    err = (n == mb(k)) && b[8*(n-1)+7];
    if (ext != v) err = 1'b1;
    val = v[63:0] & lo_mask[63:0];
  endfunction

  typedef struct {
    int          k;
    int          n;
    logic [79:0] b;
    logic [63:0] d;
    int          len;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input vec_t v);
    int k;
    k = v.k;
    out_ready[k] = 1'b1;
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      in_valid[k] = 1'b1;
      in_data[k]  = v.b[8*i +: 8];
      #1;
      if (i == v.n - 1) begin
        chk("vec_in_ready", 64'(in_ready[k]), 64'd1);
        if (v.n > 1) chk("vec_latency_pre", 64'(out_valid[k]), 64'd0);
      end
    end
    @(negedge clk);
    in_valid[k] = 1'b0;
    #1;
    chk("vec_valid", 64'(out_valid[k]), 64'd1);
    chk("vec_data", get_data(k), v.d);
    chk("vec_len", 64'(get_len(k)), 64'(v.len));
    chk("vec_err", 64'(out_err[k]), 64'(v.err));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_test(input int k, input int cycles);
    logic [79:0] cur;
    int          n;
    logic [63:0] qd[$];
    int          ql[$];
    logic        qe[$];
    logic [63:0] mv;
    logic        me;
    cur = '0;
    n = 0;
    pulse_reset();
    for (int c = 0; c < cycles + 6; c++) begin
      @(negedge clk);
      if (c < cycles) begin
        out_ready[k] = ($urandom_range(0, 9) < 7);
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        in_data[k]   = {($urandom_range(0, 9) < 7), 7'($urandom)};
      end else begin
        out_ready[k] = 1'b1;
        in_valid[k]  = 1'b0;
      end
      #1;
      if (out_valid[k] && out_ready[k]) begin
        if (qd.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rand_unexpected_output: got data %h expected no output", get_data(k));
        end else begin
          chk("rand_data", get_data(k), qd.pop_front());
          chk("rand_len", 64'(get_len(k)), 64'(ql.pop_front()));
          chk("rand_err", 64'(out_err[k]), 64'(qe.pop_front()));
        end
      end
      if (in_valid[k] && in_ready[k]) begin
        cur[8*n +: 8] = in_data[k];
        n++;
        if (!in_data[k][7] || n == mb(k)) begin
          model(k, cur, n, mv, me);
          qd.push_back(mv);
          ql.push_back(n);
          qe.push_back(me);
          n = 0;
          cur = '0;
        end
      end
    end
    chk("rand_drained", 64'(qd.size()), 64'd0);
  endtask

  initial begin
    in_data   = '0;
    in_valid  = '0;
    out_ready = '1;

    vecs[0]  = '{0, 3,  80'h268EE5,               64'h0000_0000_0009_8765, 3,  1'b0};
    vecs[1]  = '{1, 3,  80'h78BBC0,               64'h0000_0000_FFFE_1DC0, 3,  1'b0};
    vecs[2]  = '{1, 1,  80'h7F,                   64'h0000_0000_FFFF_FFFF, 1,  1'b0};
    vecs[3]  = '{1, 1,  80'h3F,                   64'h0000_0000_0000_003F, 1,  1'b0};
    vecs[4]  = '{0, 5,  80'h0FFFFFFFFF,           64'h0000_0000_FFFF_FFFF, 5,  1'b0};
    vecs[5]  = '{0, 5,  80'h1FFFFFFFFF,           64'h0000_0000_FFFF_FFFF, 5,  1'b1};
    vecs[6]  = '{0, 5,  80'h8080808080,           64'h0,                   5,  1'b1};
    vecs[7]  = '{0, 1,  80'h05,                   64'h5,                   1,  1'b0};
    vecs[8]  = '{2, 10, 80'h7F808080808080808080, 64'h8000_0000_0000_0000, 10, 1'b0};
    vecs[9]  = '{1, 5,  80'h7FFFFFFFFF,           64'h0000_0000_FFFF_FFFF, 5,  1'b0};
    vecs[10] = '{1, 5,  80'h4FFFFFFFFF,           64'h0000_0000_FFFF_FFFF, 5,  1'b1};
    vecs[11] = '{2, 2,  80'h7F80,                 64'hFFFF_FFFF_FFFF_FF80, 2,  1'b0};

    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_valid", 64'(out_valid[k]), 64'd0);
      chk("rst_data", get_data(k), 64'd0);
      chk("rst_len", 64'(get_len(k)), 64'd0);
      chk("rst_err", 64'(out_err[k]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Output stall: held result, blocked input, then release with no bubble.
    @(negedge clk);
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = 8'h0A;
    @(negedge clk);
    in_data[0] = 8'h77;
    #1;
    chk("bp_first_valid", 64'(out_valid[0]), 64'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
      chk("bp_hold_valid", 64'(out_valid[0]), 64'd1);
      chk("bp_hold_data", get_data(0), 64'h0A);
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    in_data[0]   = 8'h33;
    #1;
    chk("bp_release_ready", 64'(in_ready[0]), 64'd1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    #1;
    chk("bp_nobubble_valid", 64'(out_valid[0]), 64'd1);
    chk("bp_nobubble_data", get_data(0), 64'h33);
    chk("bp_nobubble_len", 64'(get_len(0)), 64'd1);
    @(negedge clk);
    #1;
    chk("bp_drain_valid", 64'(out_valid[0]), 64'd0);

    // Asynchronous reset in the middle of a value.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h11;
    @(negedge clk);
    in_data[0] = 8'hE5;
    @(negedge clk);
    in_data[0] = 8'h8E;
    @(negedge clk);
    in_valid[0] = 1'b0;
    #1;
    chk("rst_pre_data", get_data(0), 64'h11);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(out_valid[0]), 64'd0);
    chk("rst_async_data", get_data(0), 64'd0);
    chk("rst_async_len", 64'(get_len(0)), 64'd0);
    chk("rst_async_err", 64'(out_err[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h02;
    @(negedge clk);
    in_valid[0] = 1'b0;
    #1;
    chk("rst_resume_valid", 64'(out_valid[0]), 64'd1);
    chk("rst_resume_data", get_data(0), 64'd2);
    chk("rst_resume_len", 64'(get_len(0)), 64'd1);

    for (int k = 0; k < 3; k++) rand_test(k, 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
